minutes_seconds_timer: RTL and testbench
========================================

// Module: minutes_seconds_timer
// PURPOSE
//   Countdown timer for the microwave control path, format M:SS (0:00..9:59).
//   Built from three cascaded BCD down-counter digits: seconds units (mod 10),
//   seconds tens (mod 6) and minutes units (mod 10).
//   Loaded from the keypad/entry block and decremented once per enabled CLK edge
//   (CLK is the 1 Hz time base). Flags completion to the top-level controller.
// PARAMETERS
//   none (digit widths and moduli are fixed: 4b/mod10, 3b/mod6, 4b/mod10)
// PORTS
//   CLK                    in   1  clock; all state changes on rising edge
//   Clearn                 in   1  reset; asynchronous, active-low; clears count
//   Load                   in   1  sync load of initial_* values; priority over Enable
//   Enable                 in   1  count-down enable, one second per CLK edge
//   initial_seconds_units  in   4  BCD preset, seconds units (0..9)
//   initial_seconds_tens   in   3  preset, seconds tens (0..5)
//   initial_minutes_units  in   4  BCD preset, minutes (0..9)
//   seconds_units          out  4  current seconds units digit
//   seconds_tens           out  3  current seconds tens digit
//   minutes_units          out  4  current minutes digit
//   timer_done             out  1  high while count == 0:00
// BEHAVIOUR
//   - Reset: Clearn=0 forces all digits to 0 immediately, independent of CLK.
//     timer_done is therefore 1 during and after reset.
//   - Priority at each rising CLK edge (Clearn=1): Load > Enable > hold.
//   - Load=1: on the next edge the digits take the preset values.
//     Load overrides Enable, and the count holds at the preset while Load stays high.
//   - Preset clamping: seconds units >9 loads 9; seconds tens >5 loads 5;
//     minutes >9 loads 9. Outputs are never non-BCD.
//   - Enable=1, Load=0, count != 0:00: decrement by exactly one second per edge.
//       su>0                 : su-1
//       su==0, st>0          : su=9, st-1
//       su==0, st==0, mu>0   : su=9, st=5, mu-1   (e.g. 1:00 -> 0:59)
//   - Count == 0:00 with Enable=1: hold at 0:00. There is no wrap to 9:59.
//   - Enable=0, Load=0: hold all digits.
//   - timer_done is combinational: (mu==0 && st==0 && su==0). It is 1 on the
//     edge where the count reaches 0:00 (zero latency after that edge).
//     It drops after a nonzero Load.
//   - Loading 0:00 sets timer_done=1 after the load edge.
//   - Clearn asserted mid-count: count goes to 0:00 at once. After release the
//     count stays at 0:00 until the next Load, even if Enable=1.
//   - Clearn release is synchronised by the flop's async clear only.
//     The first counting edge is the first rising CLK edge with Clearn=1.
// TESTING
//   1. Load=1, preset 8:57, one edge -> outputs mu=8 st=5 su=7, timer_done=0.
//   2. Enable=1 for 20 edges from 8:57 -> 8:37. Digit borrow 8:50 -> 8:49 is seen.
//   3. Load=1 with Enable=0 for 5 edges -> reload to 8:57 and hold.
//      Load=1 with Enable=1 -> still holds 8:57 (Load priority).
//   4. From 8:57, Enable=1 for 537 edges -> 0:00 and timer_done=1.
//      Further enabled edges keep 0:00. Borrow 1:00 -> 0:59 is correct.
//   5. Pulse Clearn=0 for ~half a cycle mid-count (e.g. at 4:10) -> async 0:00,
//      timer_done=1; after release, 0:00 is held with Enable=1.
//   6. Preset su=12, st=7, mu=15 -> loads 9:59. Preset 0:00 -> timer_done=1 immediately.

Source files
------------

// File: rtl/minutes_seconds_timer.sv
// M:SS countdown timer (0:00..9:59) built from three cascaded BCD down-counter digits.
// Presets are clamped to legal digit values; the count sticks at 0:00 instead of wrapping.
module minutes_seconds_timer (
  input  logic       CLK,
  input  logic       Clearn,
  input  logic       Load,
  input  logic       Enable,
  input  logic [3:0] initial_seconds_units,
  input  logic [2:0] initial_seconds_tens,
  input  logic [3:0] initial_minutes_units,
  output logic [3:0] seconds_units,
  output logic [2:0] seconds_tens,
  output logic [3:0] minutes_units,
  output logic       timer_done
);

  logic [3:0] su_reg, su_next;
  logic [2:0] st_reg, st_next;
  logic [3:0] mu_reg, mu_next;
  logic [3:0] su_preset;
  logic [2:0] st_preset;
  logic [3:0] mu_preset;
  logic       at_zero;

  assign su_preset = (initial_seconds_units > 4'd9) ? 4'd9 : initial_seconds_units;
  assign st_preset = (initial_seconds_tens  > 3'd5) ? 3'd5 : initial_seconds_tens;
  assign mu_preset = (initial_minutes_units > 4'd9) ? 4'd9 : initial_minutes_units;

  assign at_zero = (su_reg == 4'd0) && (st_reg == 3'd0) && (mu_reg == 4'd0);

  always_comb begin
    su_next = su_reg;
    st_next = st_reg;
    mu_next = mu_reg;
    if (Load) begin
      su_next = su_preset;
      st_next = st_preset;
      mu_next = mu_preset;
    end else if (Enable && !at_zero) begin
      // Borrow ripples from seconds units into tens, then into minutes.
      if (su_reg != 4'd0) begin
        su_next = su_reg - 4'd1;
      end else begin
        su_next = 4'd9;
        if (st_reg != 3'd0) begin
          st_next = st_reg - 3'd1;
        end else begin
          st_next = 3'd5;
          mu_next = mu_reg - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge Clearn) begin
    if (!Clearn) begin
      su_reg <= 4'd0;
      st_reg <= 3'd0;
      mu_reg <= 4'd0;
    end else begin
      su_reg <= su_next;
      st_reg <= st_next;
      mu_reg <= mu_next;
    end
  end

  assign seconds_units = su_reg;
  assign seconds_tens  = st_reg;
  assign minutes_units = mu_reg;
  assign timer_done    = at_zero;

endmodule

// File: tb/tb_minutes_seconds_timer.sv
// Scoreboard bench for minutes_seconds_timer: the reference model tracks remaining
// time as a plain count of seconds; a monitor checks every post-edge response.
module tb_minutes_seconds_timer;

  logic       CLK;
  logic       Clearn;
  logic       Load;
  logic       Enable;
  logic [3:0] initial_seconds_units;
  logic [2:0] initial_seconds_tens;
  logic [3:0] initial_minutes_units;
  logic [3:0] seconds_units;
  logic [2:0] seconds_tens;
  logic [3:0] minutes_units;
  logic       timer_done;

  int checks   = 0;
  int failures = 0;
  int model_total = 0;
  int exp_q[$];

  minutes_seconds_timer dut (
    .CLK                   (CLK),
    .Clearn                (Clearn),
    .Load                  (Load),
    .Enable                (Enable),
    .initial_seconds_units (initial_seconds_units),
    .initial_seconds_tens  (initial_seconds_tens),
    .initial_minutes_units (initial_minutes_units),
    .seconds_units         (seconds_units),
    .seconds_tens          (seconds_tens),
    .minutes_units         (minutes_units),
    .timer_done            (timer_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int exp_total);
    int e_mu, e_st, e_su;
    logic e_done;
    e_mu   = exp_total / 60;
    e_st   = (exp_total % 60) / 10;
    e_su   = exp_total % 10;
    e_done = (exp_total == 0);
    checks++;
    if (int'(minutes_units) != e_mu || int'(seconds_tens) != e_st ||
        int'(seconds_units) != e_su || timer_done !== e_done) begin
      failures++;
      $display("FAIL %s: got %0d:%0d%0d done=%0b, expected %0d:%0d%0d done=%0b",
               name, minutes_units, seconds_tens, seconds_units, timer_done,
               e_mu, e_st, e_su, e_done);
    end else begin
      $display("ok   %s: %0d:%0d%0d done=%0b", name,
               minutes_units, seconds_tens, seconds_units, timer_done);
    end
  endtask

  // Monitor: each clock edge's expected count is checked half a cycle later.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) chk("edge", exp_q.pop_front());
  end

  function automatic int clamp(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  task automatic step(input logic ld, input logic en, input int isu, input int ist, input int imu);
    Load = ld;
    Enable = en;
    initial_seconds_units = 4'(isu);
    initial_seconds_tens  = 3'(ist);
    initial_minutes_units = 4'(imu);
    @(posedge CLK);
    if (ld) model_total = clamp(imu, 9) * 60 + clamp(ist, 5) * 10 + clamp(isu, 9);
    else if (en && model_total > 0) model_total = model_total - 1;
    exp_q.push_back(model_total);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 0, 0, 0);
  endtask

  // Short Clearn pulse inside the clock's low phase; clearing must not wait for an edge.
  task automatic reset_pulse();
    @(negedge CLK);
    #1 Clearn = 1'b0;
    model_total = 0;
    #1 chk("async_clear", 0);
    #1 Clearn = 1'b1;
  endtask

  initial begin
    Clearn = 1'b1;
    Load = 1'b0;
    Enable = 1'b0;
    initial_seconds_units = 4'd0;
    initial_seconds_tens  = 3'd0;
    initial_minutes_units = 4'd0;
    #1 Clearn = 1'b0;
    #1 chk("reset", 0);
    #5 Clearn = 1'b1;

    run(3);                          // 0:00 with Enable stays 0:00
    step(1'b1, 1'b0, 7, 5, 8);       // load 8:57
    run(20);                         // through 8:50 -> 8:49 to 8:37
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 7, 5, 8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 7, 5, 8);
    run(537);                        // 8:57 down to 0:00
    run(5);
    step(1'b1, 1'b0, 0, 3, 4);       // 4:30
    run(20);                         // 4:10
    reset_pulse();
    run(5);
    step(1'b1, 1'b0, 12, 7, 15);     // clamps to 9:59
    run(3);
    step(1'b1, 1'b0, 0, 0, 0);       // load 0:00
    step(1'b0, 1'b0, 3, 3, 3);
    step(1'b1, 1'b0, 1, 0, 0);       // 0:01
    run(2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(59) == 0) reset_pulse();
      step(($urandom_range(7) == 0), ($urandom_range(3) != 0),
           int'($urandom_range(15)), int'($urandom_range(7)), int'($urandom_range(15)));
    end

    step(1'b0, 1'b0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d responses unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
